// File: rtl/adder_pkg.sv
// Shared constants for the chunked pipelined adder: default operand width,
// chunk size and the number of pipeline stages derived from them.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Guarded so an illegal CHUNK reaches the explicit configuration error
    // instead of a divide-by-zero.
    function automatic int num_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    localparam int DEF_STAGES = num_stages(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice: sum, carry out, and the carry into the
// slice MSB (needed for signed overflow in the top slice).
module add_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // The MSB sum bit is a ^ b ^ carry-in, so the carry-in can be recovered.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, skewed operands,
// deskewed result, valid/ready handshake with whole-pipeline stall.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carryout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef logic [WIDTH-1:0] word_t;

    // Stage k inputs come from stage k-1 registers (stage 0 from the ports).
    word_t a_in [STAGES];
    word_t b_in [STAGES];
    word_t r_in [STAGES];
    word_t r_nx [STAGES];
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;

    word_t a_q [STAGES];
    word_t b_q [STAGES];
    word_t r_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    logic [STAGES-1:0][CHUNK-1:0] sum_w;
    logic [STAGES-1:0]            cout_w;
    logic [STAGES-1:0]            cmsb_w;

    logic stall;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    assign out_valid = v_q[LAST];
    assign s         = r_q[LAST];
    assign carryout  = c_q[LAST];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(.CHUNK(CHUNK)) u_add (
            .a   (a_in[k][k*CHUNK +: CHUNK]),
            .b   (b_in[k][k*CHUNK +: CHUNK]),
            .cin (c_in[k]),
            .sum (sum_w[k]),
            .cout(cout_w[k]),
            .cmsb(cmsb_w[k])
        );
    end

    // Subtraction is x + ~y + 1, so carryin is ignored in sub mode.
    always_comb begin
        a_in[0] = x;
        b_in[0] = sub ? ~y : y;
        c_in[0] = sub ? 1'b1 : carryin;
        v_in[0] = in_valid;
        r_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
            r_in[k] = r_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            r_nx[k]                    = r_in[k];
            r_nx[k][k*CHUNK +: CHUNK]  = sum_w[k];
        end
    end

    // NOTE: the data registers are reset too, not just the valid bits, because
    // the final-stage result must read as zero while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q   <= v_in;
            c_q   <= cout_w;
            ovf_q <= cout_w[LAST] ^ cmsb_w[LAST];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                r_q[k] <= r_nx[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, CHUNK=4): directed cases plus
// randomized traffic scored against an arithmetic reference model.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = num_stages(WIDTH, CHUNK);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             carryin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             carryout;
    logic             ovf;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .carryin  (carryin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .carryout (carryout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               stamp;
    } exp_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sb);
        exp_t   e;
        int     sa;
        int     sbv;
        int     sv;
        longint ua;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            sv  = sa - sbv;
        end else begin
            ua  = longint'(a) + longint'(b) + longint'(ci);
            e.s = 16'(ua);
            e.c = (ua > 65535);
            sv  = sa + sbv + int'(ci);
        end
        e.o     = (sv > 32767) || (sv < -32768);
        e.stamp = 0;
        return e;
    endfunction

    // Scoreboard: expected results in acceptance order, stamped with the
    // number of non-stalled clock edges seen so far.
    exp_t q[$];
    exp_t mon_e;
    int   adv = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stale_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("s", 32'(s), 32'(q[0].s));
                    check("carryout", 32'(carryout), 32'(q[0].c));
                    check("ovf", 32'(ovf), 32'(q[0].o));
                    if (out_ready) begin
                        check("latency", 32'(adv - q[0].stamp), 32'(STAGES));
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e       = model(x, y, carryin, sub);
                mon_e.stamp = adv;
                q.push_back(mon_e);
            end
            if (!(out_valid && !out_ready)) adv++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Issue one set, wait for its result and compare with literal values.
    task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci, input logic sb, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
        int n;
        x = a; y = b; carryin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 12);
        check({tag, "_lat"}, 32'(n), 32'(STAGES));
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(carryout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
    endtask

    task automatic drive_random();
        x = 16'($urandom); y = 16'($urandom);
        carryin = 1'($urandom); sub = 1'($urandom);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(carryout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_one("add_c0",   16'h0008, 16'h0001, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
        run_one("add_c1",   16'h0008, 16'h0001, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0);
        run_one("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_neg1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_one("sub_ovf1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: 8 back-to-back sets, out_ready low for 3 cycles
        fork
            begin
                logic acc;
                for (int i = 0; i < 8; i++) begin
                    drive_random();
                    in_valid = 1'b1;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                    end while (!acc);
                end
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                check("bp_first_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_high", 32'(in_ready), 32'd1);
            end
        join
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_drained", 32'(q.size()), 32'd0);

        // Reset with 3 sets in flight
        for (int i = 0; i < 3; i++) begin
            drive_random();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 four cycles later
        for (int i = 0; i < 4; i++) begin
            drive_random();
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bubble_pattern", 32'(out_valid), 32'((i % 2) == 0));
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            drive_random();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("final_drain", 32'(q.size()), 32'd0);
        repeat (STAGES + 2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
